// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the ID-stage hazard logic and the per-opcode result latencies.
package hazard_scoreboard_pkg;

    localparam int unsigned DEF_REG_W = 5;
    localparam int unsigned DEF_LAT_W = 3;

    localparam logic [DEF_REG_W-1:0] ZERO_REG = '0;

    // Cycles after issue until the result can be forwarded, by opcode class.
    localparam logic [DEF_LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [DEF_LAT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [DEF_LAT_W-1:0] LAT_MUL  = 3'd3;
    localparam logic [DEF_LAT_W-1:0] LAT_DIV  = 3'd6;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: countdown to the cycle a register's pending result becomes forwardable.
module sb_entry #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic             busy,
    output logic [LAT_W-1:0] cnt
);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    // A new issue overrides the decrement of an expiring entry.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = lat;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign cnt  = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard for RAW/WAW stalls, IF flush
// on control transfers, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = DEF_REG_W,
    parameter int unsigned LAT_W    = DEF_LAT_W,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_dst_we,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             ext_stall,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             stat_clr,
    output logic             stall,
    output logic             flush,
    output logic             issue,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [LAT_W-1:0]    pend [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                raw_rs, raw_rt, waw;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    assign pend[0] = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LAT_W(LAT_W)
        ) u_entry (
            .clk  (clk),
            .rst_n(rst_n),
            .load (issue && id_dst_we && (id_dst == REG_W'(r))),
            .lat  (id_lat),
            .busy (busy[r]),
            .cnt  (pend[r])
        );
    end

    // Sources see pre-update state, so an instruction never stalls on its own destination.
    always_comb begin
        raw_rs = id_use_rs && (id_rs != REG_W'(ZERO_REG)) && busy[id_rs];
        raw_rt = id_use_rt && (id_rt != REG_W'(ZERO_REG)) && busy[id_rt];
        // Strict compare: equal-latency writes already retire in order.
        waw    = id_dst_we && (id_dst != REG_W'(ZERO_REG)) && (pend[id_dst] > id_lat);
        stall  = (id_valid && (raw_rs || raw_rt || waw)) || ext_stall;
        issue  = id_valid && !stall;
        flush  = jump || branch_taken;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (stall && id_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations, negedge monitor compares.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_dst_we = 1'b0;
    logic [2:0]  id_lat = '0;
    logic        ext_stall = 1'b0, jump = 1'b0, branch_taken = 1'b0, stat_clr = 1'b0;
    logic        stall, flush, issue, stall4, flush4, issue4;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_dst_we(id_dst_we),
        .id_lat(id_lat), .ext_stall(ext_stall), .jump(jump), .branch_taken(branch_taken),
        .stat_clr(stat_clr), .stall(stall), .flush(flush), .issue(issue),
        .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_dst_we(id_dst_we),
        .id_lat(id_lat), .ext_stall(ext_stall), .jump(jump), .branch_taken(branch_taken),
        .stat_clr(stat_clr), .stall(stall4), .flush(flush4), .issue(issue4),
        .stall_cycles(stall_cycles4)
    );

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; int dst; bit we; int lat;
        bit ext; bit jmp; bit br; bit clr; bit rst;
    } stim_t;

    typedef struct {
        int cyc; bit stall; bit flush; bit issue; longint cnt; longint cnt4;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: absolute cycle at which each register's result is forwardable.
    int unsigned cyc = 0;
    int unsigned avail [32];
    longint      m_cnt = 0;
    longint      m_cnt4 = 0;

    function automatic int unsigned pend_of(input int r);
        if (r == 0 || avail[r] <= cyc) return 0;
        return avail[r] - cyc;
    endfunction

    task automatic check(input string name, input longint act, input longint req, input int c);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit   raw, waw;
        @(posedge clk);
        #1;
        rst_n = !s.rst;
        id_valid = s.v; id_rs = 5'(s.rs); id_rt = 5'(s.rt);
        id_use_rs = s.urs; id_use_rt = s.urt; id_dst = 5'(s.dst); id_dst_we = s.we;
        id_lat = 3'(s.lat); ext_stall = s.ext; jump = s.jmp; branch_taken = s.br;
        stat_clr = s.clr;
        if (s.rst) begin
            foreach (avail[i]) avail[i] = 0;
            m_cnt = 0;
            m_cnt4 = 0;
        end
        raw = s.v && ((s.urs && s.rs != 0 && pend_of(s.rs) != 0) ||
                      (s.urt && s.rt != 0 && pend_of(s.rt) != 0));
        waw = s.v && s.we && s.dst != 0 && pend_of(s.dst) > s.lat;
        e.cyc = int'(cyc);
        e.stall = raw || waw || s.ext;
        e.issue = s.v && !e.stall;
        e.flush = s.jmp || s.br;
        e.cnt = m_cnt;
        e.cnt4 = m_cnt4;
        q.push_back(e);
        if (!s.rst) begin
            if (s.clr) begin
                m_cnt = 0;
                m_cnt4 = 0;
            end else if (e.stall && s.v) begin
                m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (e.issue && s.we && s.dst != 0) avail[s.dst] = cyc + 1 + s.lat;
        end
        cyc++;
    endtask

    function automatic stim_t nop();
        stim_t s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t prod(input int dst, input int lat);
        stim_t s = nop();
        s.v = 1; s.dst = dst; s.we = 1; s.lat = lat;
        return s;
    endfunction

    function automatic stim_t cons(input int rs);
        stim_t s = nop();
        s.v = 1; s.rs = rs; s.urs = 1; s.rt = rs; s.urt = 1;
        return s;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stall", longint'(stall), longint'(e.stall), e.cyc);
            check("flush", longint'(flush), longint'(e.flush), e.cyc);
            check("issue", longint'(issue), longint'(e.issue), e.cyc);
            check("stall_cycles", longint'(stall_cycles), e.cnt, e.cyc);
            check("stall4", longint'(stall4), longint'(e.stall), e.cyc);
            check("stall_cycles4", longint'(stall_cycles4), e.cnt4, e.cyc);
        end
    end

    initial begin
        stim_t s;
        foreach (avail[i]) avail[i] = 0;

        s = nop(); s.rst = 1;
        step(s);
        step(s);

        // Load-use: one bubble.
        step(prod(8, 1));
        step(cons(8));
        step(cons(8));
        step(nop());
        @(negedge clk);
        check("loaduse_count", longint'(stall_cycles), 1, int'(cyc));

        // Register zero never becomes busy.
        step(prod(0, 5));
        step(cons(0));

        // Divide then WAW by a zero-latency write: four stalls.
        s = nop(); s.clr = 1;
        step(s);
        step(prod(9, 6));
        step(nop());
        step(nop());
        repeat (5) step(prod(9, 0));
        step(cons(9));
        step(nop());
        @(negedge clk);
        check("waw_count", longint'(stall_cycles), 4, int'(cyc));

        // Jump during a RAW stall; the stalled instruction must not allocate r4.
        step(prod(3, 2));
        s = cons(3); s.dst = 4; s.we = 1; s.lat = 7; s.jmp = 1;
        step(s);
        s = cons(3); s.br = 1;
        step(s);
        step(nop());
        step(cons(4));

        // Expiring entry overridden by a new issue.
        step(prod(5, 2));
        step(nop());
        step(prod(5, 3));
        repeat (4) step(cons(5));

        // Reset mid-flight clears pending entries and the counter.
        step(prod(10, 5));
        step(nop());
        s = nop(); s.rst = 1;
        step(s);
        step(cons(10));
        step(nop());
        @(negedge clk);
        check("reset_count", longint'(stall_cycles), 0, int'(cyc));

        // Saturation of the narrow counter, then clear.
        s = nop(); s.clr = 1;
        step(s);
        s = nop(); s.v = 1; s.ext = 1;
        repeat (20) step(s);
        step(nop());
        @(negedge clk);
        check("sat_count4", longint'(stall_cycles4), 15, int'(cyc));
        check("sat_count32", longint'(stall_cycles), 20, int'(cyc));
        s = nop(); s.clr = 1;
        step(s);
        step(nop());
        @(negedge clk);
        check("clr_count4", longint'(stall_cycles4), 0, int'(cyc));

        // Randomised traffic over a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            s.v   = ($urandom_range(9, 0) < 8);
            s.rs  = $urandom_range(7, 0);
            s.rt  = $urandom_range(7, 0);
            s.urs = $urandom_range(1, 0);
            s.urt = $urandom_range(1, 0);
            s.dst = $urandom_range(7, 0);
            s.we  = ($urandom_range(3, 0) != 0);
            s.lat = $urandom_range(7, 0);
            s.ext = ($urandom_range(9, 0) == 0);
            s.jmp = ($urandom_range(9, 0) == 0);
            s.br  = ($urandom_range(9, 0) == 0);
            s.clr = ($urandom_range(49, 0) == 0);
            s.rst = ($urandom_range(199, 0) == 0);
            step(s);
        end
        step(nop());

        repeat (2) @(posedge clk);
        check("queue_drained", longint'(q.size()), 0, int'(cyc));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order MIPS pipeline, placed at the ID stage. Replaces single-cycle load-use detection with a per-register countdown scoreboard, so producers with any result latency (loads, multi-cycle multiply/divide, slow memory) stall dependent consumers exactly as long as needed. It also enforces in-order register writes (WAW), merges external stall requests, drives the IF/ID flush on taken control transfers, and keeps a stall-cycle performance counter.

## Interface
- `NUM_REGS`, 32: architectural registers; register 0 is hard-wired zero.
- `REG_W`, 5: register index width, clog2(NUM_REGS).
- `LAT_W`, 3: latency field width; max latency 2^LAT_W-1.
- `CNT_W`, 32: stall counter width.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: an instruction occupies ID.
- `id_rs`, `id_rt` input REG_W: source indices.
- `id_use_rs`, `id_use_rt` input 1: the source is actually read.
- `id_dst` input REG_W: destination index.
- `id_dst_we` input 1: the instruction writes `id_dst`.
- `id_lat` input LAT_W: cycles after issue until the result is forwardable; 0 means available to the next instruction via forwarding.
- `ext_stall` input 1: stall request from a busy downstream unit.
- `jump`, `branch_taken` input 1: control transfer resolved in ID.
- `stat_clr` input 1: synchronous clear of `stall_cycles`.
- `stall` output 1: hold PC and IF/ID; insert a bubble into ID/EX.
- `flush` output 1: squash the instruction in IF.
- `issue` output 1: ID instruction advances this cycle.
- `stall_cycles` output CNT_W: saturating count of stalled cycles.

## Operation
- Scoreboard: one LAT_W countdown `pend[r]` per register r in 1..NUM_REGS-1. `pend[0]` is constant 0. A register is busy when `pend[r]` is not 0.
- RAW hazard: `id_valid` and ((`id_use_rs` and `id_rs`≠0 and busy(`id_rs`)) or (`id_use_rt` and `id_rt`≠0 and busy(`id_rt`))).
- WAW hazard: `id_valid`, `id_dst_we`, `id_dst`≠0, and `pend[id_dst]` > `id_lat`.
- `stall` = RAW or WAW or `ext_stall`.
- `issue` = `id_valid` and not `stall`.
- `flush` = `jump` or `branch_taken`. It is independent of `stall`, because the IF instruction is wrong-path either way.
- Per-cycle update for each r, in priority order:
  - `issue`, `id_dst_we`, and `id_dst`==r: `pend[r]` <= `id_lat`. The new issue overrides a same-cycle decrement.
  - otherwise, `pend[r]`≠0: `pend[r]` <= `pend[r]`-1.
  - otherwise: hold 0.
- A stalled or flushed instruction never writes the scoreboard. Only `issue` allocates.
- `stall_cycles`:
  - `stat_clr` has priority and writes 0.
  - otherwise increments on each cycle with `stall` and `id_valid`.
  - saturates at all-ones.

## Timing
- Reset (`rst_n` low, asynchronous): all `pend` = 0 and `stall_cycles` = 0. Combinational outputs follow the inputs, so `stall` = `ext_stall` and `issue` = `id_valid` and not `ext_stall`.
- Reset asserted mid-operation clears all pending entries immediately. There is no stall on the first cycle after release unless `ext_stall` is high.
- `stall`, `flush`, `issue` are combinational from the current `pend` state and ID inputs. There is no cycle of latency.
- A producer issued at cycle t with `id_lat` = L makes its destination busy during cycles t+1..t+L. A consumer in ID at cycle t+L+1 issues.
- A classic load-use uses L = 1, giving exactly one bubble.
- Dependent consumer directly behind the producer: stall count = L.
- Source equal to destination in the same instruction: sources are checked against pre-update state, so there is no self-stall.
- WAW with equal latency does not stall. Because of the strict `>`, equal-latency writes complete in order.

## Structure
- Shared pipeline package holds `REG_W` and `LAT_W` defaults and the `ZERO_REG` constant. The ID decode uses the same package to build `id_lat` per opcode class (`LAT_ALU`=0, `LAT_LOAD`=1, `LAT_MUL`, `LAT_DIV`).
- One natural sub-module: `sb_entry`, a single countdown register with load/decrement/busy. It is instantiated NUM_REGS-1 times via generate.
- RAW/WAW muxing and the stall counter live in the top.

## Test plan
- Load-use:
  - issue `lw` with dst=8 and lat=1, then `add` with rs=8 → `stall`=1 for exactly 1 cycle, then `issue`=1.
  - `stall_cycles` reads 1.
- Zero register: producer with dst=0 and lat=5, then consumer with rs=0 → no stall; `pend` stays all-zero.
- Multi-cycle and WAW:
  - `div` with dst=9 and lat=6. Two cycles later, an ALU write to 9 with lat=0 stalls until `pend[9]`=0: 4 stall cycles.
  - Then it issues and `pend[9]` stays 0.
- Simultaneous events: `jump`=1 during a RAW stall → `flush`=1 and `stall`=1 in the same cycle; the scoreboard is unchanged by the stalled instruction.
- Override on expiry: `pend[5]`=1 and issue of a new write to 5 with lat=3 in the same cycle → next cycle `pend[5]`=3, not 0.
- Reset and counter:
  - assert `rst_n` low while `pend[10]`=4 → next consumer of 10 after release issues without stall.
  - `stall_cycles` is 0.
  - with `CNT_W`=4, 20 stall cycles → saturates at 15; `stat_clr` returns it to 0.
